// File: rtl/irrigation_sequencer.sv
// Irrigation plant sequencer: debounced sensor front end feeding a timed,
// interlocked IDLE/SETTLE/IRRIGATE/FILL/FAULT controller with a run counter.
module irrigation_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 8,
    parameter int MIN_RUN_CYCLES  = 16,
    parameter int MAX_RUN_CYCLES  = 64,
    parameter int FILL_TIMEOUT    = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       low_water_level,
    input  logic       mid_water_level,
    input  logic       high_water_level,
    input  logic       earth_humidity,
    input  logic       air_humidity,
    input  logic       low_temperature,
    input  logic       enable,
    input  logic       fault_clear,
    output logic       water_supply_valvule,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       alarm,
    output logic [2:0] state,
    output logic [7:0] run_count
);

    localparam int N_SENS = 6;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam int PW     = $clog2(DEBOUNCE_CYCLES + 3);

    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRIME_LAST  = PW'(DEBOUNCE_CYCLES + 2);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    MIN_LAST    = 8'(MIN_RUN_CYCLES - 1);
    localparam logic [7:0]    MAX_LAST    = 8'(MAX_RUN_CYCLES - 1);
    localparam logic [7:0]    FILL_LAST   = 8'(FILL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_FILL     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    logic [N_SENS-1:0] w_raw;
    logic [N_SENS-1:0] r_sync1;
    logic [N_SENS-1:0] r_sync2;
    logic [N_SENS-1:0] r_filt;
    logic [CW-1:0]     r_db_cnt [N_SENS];

    logic [PW-1:0] r_prime;
    logic          w_primed;
    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_timer;
    logic          r_mode;
    logic [7:0]    r_run_count;
    logic          w_run_done;

    logic w_f_low, w_f_mid, w_f_high, w_f_earth, w_f_air, w_f_temp;
    logic w_conflict;
    logic w_mode_eval;

    assign w_raw = {low_temperature, air_humidity, earth_humidity,
                    high_water_level, mid_water_level, low_water_level};

    // Sensor front end: 2-flop synchronizer, then a per-sensor run-length filter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < N_SENS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_SENS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_filt[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_f_low     = r_filt[0];
    assign w_f_mid     = r_filt[1];
    assign w_f_high    = r_filt[2];
    assign w_f_earth   = r_filt[3];
    assign w_f_air     = r_filt[4];
    assign w_f_temp    = r_filt[5];
    assign w_conflict  = (w_f_mid & ~w_f_low) | (w_f_high & ~w_f_mid);
    assign w_mode_eval = ~w_f_air & ~w_f_temp & w_f_mid;
    assign w_primed    = (r_prime == PRIME_LAST);

    // Next-state logic; enable and fault_clear act directly so aborts take one cycle
    always_comb begin
        w_next_state = r_state;
        w_run_done   = 1'b0;
        if (!w_primed) begin
            w_next_state = r_state;
        end else if (w_conflict) begin
            w_next_state = ST_FAULT;
        end else if (!enable && r_state != ST_FAULT) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_f_low)        w_next_state = ST_FILL;
                    else if (!w_f_earth) w_next_state = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_f_earth || !w_f_low)       w_next_state = ST_IDLE;
                    else if (r_timer == SETTLE_LAST) w_next_state = ST_IRRIGATE;
                end
                ST_IRRIGATE: begin
                    if (!w_f_low) begin
                        w_next_state = ST_FILL;
                        w_run_done   = 1'b1;
                    end else if (r_timer >= MIN_LAST && w_f_earth) begin
                        w_next_state = ST_IDLE;
                        w_run_done   = 1'b1;
                    end else if (r_timer == MAX_LAST) begin
                        w_next_state = ST_IDLE;
                        w_run_done   = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (w_f_high)                  w_next_state = ST_IDLE;
                    else if (r_timer == FILL_LAST) w_next_state = ST_FAULT;
                end
                ST_FAULT: begin
                    if (fault_clear) w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= 8'd0;
            r_mode      <= 1'b0;
            r_run_count <= 8'd0;
            r_prime     <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= (w_next_state != r_state) ? 8'd0 : r_timer + 8'd1;
            if (!w_primed) begin
                r_prime <= r_prime + 1'b1;
            end
            if (w_next_state == ST_SETTLE && r_state != ST_SETTLE) begin
                r_mode <= w_mode_eval;
            end
            if (w_run_done && r_run_count != 8'hFF) begin
                r_run_count <= r_run_count + 8'd1;
            end
        end
    end

    assign state                = r_state;
    assign run_count            = r_run_count;
    assign water_supply_valvule = (r_state == ST_FILL);
    assign splinker_bomb        = (r_state == ST_IRRIGATE) &  r_mode;
    assign dripper_valvule      = (r_state == ST_IRRIGATE) & ~r_mode;
    assign alarm                = (r_state == ST_FAULT);

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Randomized bench for irrigation_sequencer against a cycle-level behavioural model.
module tb_irrigation_sequencer;

    localparam int DEB   = 4;
    localparam int SETT  = 8;
    localparam int MINR  = 16;
    localparam int MAXR  = 64;
    localparam int FILLT = 128;

    logic       clock;
    logic       reset;
    logic       low_water_level, mid_water_level, high_water_level;
    logic       earth_humidity, air_humidity, low_temperature;
    logic       enable, fault_clear;
    logic       water_supply_valvule, splinker_bomb, dripper_valvule, alarm;
    logic [2:0] state;
    logic [7:0] run_count;

    int n_tests;
    int n_fail;

    irrigation_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SETT),
        .MIN_RUN_CYCLES (MINR),
        .MAX_RUN_CYCLES (MAXR),
        .FILL_TIMEOUT   (FILLT)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .low_water_level     (low_water_level),
        .mid_water_level     (mid_water_level),
        .high_water_level    (high_water_level),
        .earth_humidity      (earth_humidity),
        .air_humidity        (air_humidity),
        .low_temperature     (low_temperature),
        .enable              (enable),
        .fault_clear         (fault_clear),
        .water_supply_valvule(water_supply_valvule),
        .splinker_bomb       (splinker_bomb),
        .dripper_valvule     (dripper_valvule),
        .alarm               (alarm),
        .state               (state),
        .run_count           (run_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: state codes 0..4, timer = cycles spent in the current state
    int       m_state, m_timer, m_runs, m_since;
    bit       m_mode;
    bit [5:0] m_sync1, m_sync2, m_filt;
    bit [5:0] m_hist [DEB];

    task automatic model_edge();
        bit [5:0] s;
        int       nxt;
        bit       done, conf, agree;
        bit       fl, fm, fh, fe, fa, ft;
        if (reset) begin
            m_state = 0; m_timer = 0; m_runs = 0; m_since = 0; m_mode = 1'b0;
            m_sync1 = '0; m_sync2 = '0; m_filt = '0;
            for (int k = 0; k < DEB; k++) m_hist[k] = '0;
            return;
        end
        fl = m_filt[0]; fm = m_filt[1]; fh = m_filt[2];
        fe = m_filt[3]; fa = m_filt[4]; ft = m_filt[5];
        nxt  = m_state;
        done = 1'b0;
        if (m_since >= DEB + 2) begin
            conf = (fm && !fl) || (fh && !fm);
            if (conf) nxt = 4;
            else if (!enable && m_state != 4) nxt = 0;
            else begin
                case (m_state)
                    0: begin
                        if (!fl) nxt = 3;
                        else if (!fe) nxt = 1;
                    end
                    1: begin
                        if (fe || !fl) nxt = 0;
                        else if (m_timer == SETT - 1) nxt = 2;
                    end
                    2: begin
                        if (!fl) begin nxt = 3; done = 1'b1; end
                        else if (m_timer >= MINR - 1 && fe) begin nxt = 0; done = 1'b1; end
                        else if (m_timer == MAXR - 1) begin nxt = 0; done = 1'b1; end
                    end
                    3: begin
                        if (fh) nxt = 0;
                        else if (m_timer == FILLT - 1) nxt = 4;
                    end
                    4: if (fault_clear) nxt = 0;
                    default: nxt = 0;
                endcase
            end
        end
        if (done && m_runs < 255) m_runs++;
        if (nxt == 1 && m_state != 1) m_mode = !fa && !ft && fm;
        m_timer = (nxt != m_state) ? 0 : m_timer + 1;
        m_state = nxt;
        if (m_since < 1000) m_since++;
        // A filtered value follows the synchronized input once the last DEB samples all agree
        s = m_sync2;
        for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
        for (int i = 0; i < 6; i++) begin
            agree = 1'b1;
            for (int k = 0; k < DEB; k++) if (m_hist[k][i] != s[i]) agree = 1'b0;
            if (agree) m_filt[i] = s[i];
        end
        m_sync2 = m_sync1;
        m_sync1 = {low_temperature, air_humidity, earth_humidity,
                   high_water_level, mid_water_level, low_water_level};
    endtask

    task automatic compare_out();
        logic [3:0] exp_act;
        exp_act = {m_state == 3, m_state == 2 && m_mode, m_state == 2 && !m_mode, m_state == 4};
        chk("state", 32'(state), 32'(m_state));
        chk("actuators", 32'({water_supply_valvule, splinker_bomb, dripper_valvule, alarm}),
            32'(exp_act));
        chk("run_count", 32'(run_count), 32'(m_runs));
    endtask

    task step();
        model_edge();
        @(negedge clock);
        compare_out();
    endtask

    // Random stimulus state
    int ph_left, lvl, g_left, g_bit;
    bit conf_pat, e_v, a_v, t_v, en_v;

    task automatic gen();
        bit [5:0] sens;
        if (ph_left == 0) begin
            ph_left  = $urandom_range(5, 200);
            lvl      = $urandom_range(0, 3);
            conf_pat = ($urandom_range(0, 9) == 0);
            e_v      = 1'($urandom_range(0, 1));
            a_v      = 1'($urandom_range(0, 1));
            t_v      = 1'($urandom_range(0, 1));
            en_v     = ($urandom_range(0, 7) != 0);
        end
        ph_left--;
        if ($urandom_range(0, 39) == 0) e_v = !e_v;
        sens[0] = (lvl >= 1); sens[1] = (lvl >= 2); sens[2] = (lvl >= 3);
        if (conf_pat) begin
            if ($urandom_range(0, 1) == 0) sens[2:0] = 3'b010;
            else                           sens[2:0] = 3'b101;
        end
        sens[3] = e_v; sens[4] = a_v; sens[5] = t_v;
        if (g_left == 0 && $urandom_range(0, 49) == 0) begin
            g_left = $urandom_range(1, DEB - 1);
            g_bit  = $urandom_range(0, 5);
        end
        if (g_left > 0) begin
            sens[g_bit] = !sens[g_bit];
            g_left--;
        end
        {low_temperature, air_humidity, earth_humidity,
         high_water_level, mid_water_level, low_water_level} = sens;
        enable      = en_v;
        fault_clear = ($urandom_range(0, 15) == 0);
        reset       = ($urandom_range(0, 1499) == 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        ph_left = 0; g_left = 0; g_bit = 0;
        reset = 1'b1; enable = 1'b0; fault_clear = 1'b0;
        low_water_level = 1'b0; mid_water_level = 1'b0; high_water_level = 1'b0;
        earth_humidity = 1'b0; air_humidity = 1'b0; low_temperature = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_actuators", 32'({water_supply_valvule, splinker_bomb, dripper_valvule, alarm}), 32'd0);
        chk("rst_run_count", 32'(run_count), 32'd0);

        // Priming and a full-length sprinkler run
        reset = 1'b0; enable = 1'b1;
        low_water_level = 1'b1; mid_water_level = 1'b1;
        repeat (120) step();

        // Short earth-driven runs until the counter saturates
        for (int r = 0; r < 270; r++) begin
            air_humidity   = 1'($urandom_range(0, 1));
            earth_humidity = 1'b0;
            repeat (30) step();
            earth_humidity = 1'b1;
            repeat (12) step();
        end
        chk("run_sat", 32'(run_count), 32'd255);

        // Mixed random operation including conflicts, refills, aborts and resets
        reset = 1'b1;
        step();
        repeat (20000) begin
            gen();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
